forward_hazard_unit: RTL and testbench

- Drives `sel_src_1` / `sel_src_2` for the execution stage's two operand muxes.
- Generates the pipeline freeze that stops IF/ID on unresolvable read-after-write hazards.
- Keeps its own shadow copy of the EX, MEM and WB stages, holding destination, source and control fields.
- Sits beside the ID stage and is the producer side of the forwarding-select interface the execution stage consumes.

---
 rtl/hazard_pkg.sv | 55 +++++
 rtl/hazard_stage_reg.sv | 33 +++
 rtl/forward_hazard_unit.sv | 141 ++++++++++++++
 tb/tb_forward_hazard_unit.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the forwarding / hazard unit: operand-mux select codes,
// the shadow pipeline-stage entry and the helpers that compare against it.
package hazard_pkg;

  // EX operand-mux select codes; 2'b11 is never produced.
  localparam logic [1:0] SEL_REG = 2'b00;  // register-file value
  localparam logic [1:0] SEL_MEM = 2'b01;  // MEM-stage ALU result
  localparam logic [1:0] SEL_WB  = 2'b10;  // WB value

  // One shadow copy of a pipeline stage.
  typedef struct packed {
    logic       valid;
    logic       wb_en;
    logic       mem_r_en;
    logic [3:0] dest;
    logic [3:0] src1;
    logic       src1_used;
    logic [3:0] src2;
    logic       src2_used;
  } stage_t;

  // Empty slot: nothing valid, nothing written, nothing loaded.
  localparam stage_t BUBBLE = '{
    valid:     1'b0,
    wb_en:     1'b0,
    mem_r_en:  1'b0,
    dest:      4'h0,
    src1:      4'h0,
    src1_used: 1'b0,
    src2:      4'h0,
    src2_used: 1'b0
  };

  // True when a used source register is produced by a live writer in the entry.
  function automatic logic dest_match(input logic [3:0] src, input logic used,
                                      input stage_t entry);
    return used & entry.valid & entry.wb_en & (entry.dest == src);
  endfunction

  // Youngest-producer-wins operand select. A load in MEM has no data yet,
  // so it is skipped and the WB stage is considered instead.
  function automatic logic [1:0] fwd_select(input logic [3:0] src, input logic used,
                                            input stage_t mem_entry, input stage_t wb_entry);
    logic [1:0] sel;
    if (dest_match(src, used, mem_entry) && !mem_entry.mem_r_en) begin
      sel = SEL_MEM;
    end else if (dest_match(src, used, wb_entry)) begin
      sel = SEL_WB;
    end else begin
      sel = SEL_REG;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One shadow pipeline-stage entry. On 'load' it captures either the incoming
// entry or a bubble; otherwise it keeps its contents.
module hazard_stage_reg
  import hazard_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   bubble,
  input  stage_t d,
  output stage_t q
);

  stage_t q_r;

  // Stage register: reset to a bubble, advance when loaded, otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q_r <= BUBBLE;
    end else if (load) begin
      if (bubble) begin
        q_r <= BUBBLE;
      end else begin
        q_r <= d;
      end
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/forward_hazard_unit.sv
// Forwarding and hazard unit sitting beside ID. It tracks its own shadow copy
// of EX/MEM/WB, drives the EX operand-mux selects from that copy alone, and
// raises a freeze for read-after-write hazards forwarding cannot cover.
module forward_hazard_unit
  import hazard_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fwd_en,
  input  logic             hold,
  input  logic [3:0]       id_src1,
  input  logic             id_src1_used,
  input  logic [3:0]       id_src2,
  input  logic             id_src2_used,
  input  logic [3:0]       id_dest,
  input  logic             id_wb_en,
  input  logic             id_mem_r_en,
  input  logic             branch_taken,
  output logic [1:0]       sel_src_1,
  output logic [1:0]       sel_src_2,
  output logic             hazard_stall,
  output logic             flush,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  stage_t           id_entry_s;
  stage_t           ex_r;
  stage_t           mem_r;
  stage_t           wb_r;
  logic             advance_s;
  logic             ex_bubble_s;
  logic             src1_ex_hit_s;
  logic             src2_ex_hit_s;
  logic             src1_mem_hit_s;
  logic             src2_mem_hit_s;
  logic             raw_hazard_s;
  logic [CNT_W-1:0] stall_cnt_r;
  logic             unused_fields_s;

  // Package the ID instruction as the entry that will move into EX.
  always_comb begin
    id_entry_s           = BUBBLE;
    id_entry_s.valid     = 1'b1;
    id_entry_s.wb_en     = id_wb_en;
    id_entry_s.mem_r_en  = id_mem_r_en;
    id_entry_s.dest      = id_dest;
    id_entry_s.src1      = id_src1;
    id_entry_s.src1_used = id_src1_used;
    id_entry_s.src2      = id_src2;
    id_entry_s.src2_used = id_src2_used;
  end

  // A memory wait freezes everything; a stall or a squash sends a bubble into EX.
  assign advance_s   = ~hold;
  assign ex_bubble_s = hazard_stall | flush;

  hazard_stage_reg u_ex_stage (
    .clk    (clk),
    .rst    (rst),
    .load   (advance_s),
    .bubble (ex_bubble_s),
    .d      (id_entry_s),
    .q      (ex_r)
  );

  hazard_stage_reg u_mem_stage (
    .clk    (clk),
    .rst    (rst),
    .load   (advance_s),
    .bubble (1'b0),
    .d      (ex_r),
    .q      (mem_r)
  );

  hazard_stage_reg u_wb_stage (
    .clk    (clk),
    .rst    (rst),
    .load   (advance_s),
    .bubble (1'b0),
    .d      (mem_r),
    .q      (wb_r)
  );

  // Operand selects depend only on the shadow stages, so they are stable for
  // the whole cycle an instruction sits in EX.
  always_comb begin
    sel_src_1 = SEL_REG;
    sel_src_2 = SEL_REG;
    if (fwd_en) begin
      sel_src_1 = fwd_select(ex_r.src1, ex_r.src1_used, mem_r, wb_r);
      sel_src_2 = fwd_select(ex_r.src2, ex_r.src2_used, mem_r, wb_r);
    end else begin
      sel_src_1 = SEL_REG;
      sel_src_2 = SEL_REG;
    end
  end

  // Hazard detection: with forwarding only load-use in EX blocks; without it
  // any writer still in EX or MEM blocks. WB writes on the falling edge, so
  // it never blocks.
  always_comb begin
    src1_ex_hit_s  = dest_match(id_src1, id_src1_used, ex_r);
    src2_ex_hit_s  = dest_match(id_src2, id_src2_used, ex_r);
    src1_mem_hit_s = dest_match(id_src1, id_src1_used, mem_r);
    src2_mem_hit_s = dest_match(id_src2, id_src2_used, mem_r);
    if (fwd_en) begin
      raw_hazard_s = ex_r.mem_r_en & (src1_ex_hit_s | src2_ex_hit_s);
    end else begin
      raw_hazard_s = src1_ex_hit_s | src2_ex_hit_s | src1_mem_hit_s | src2_mem_hit_s;
    end
  end

  // A taken branch squashes the ID instruction, so its hazard is irrelevant.
  assign flush        = branch_taken;
  assign hazard_stall = raw_hazard_s & ~branch_taken;

  // Saturating stall-cycle counter; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_r <= CNT_ZERO;
    end else if (hazard_stall && !hold && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + CNT_ONE;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_count = stall_cnt_r;

  // Shadow fields carried for completeness that no decision here consumes.
  assign unused_fields_s = ^{mem_r.src1, mem_r.src1_used, mem_r.src2, mem_r.src2_used,
                             wb_r.mem_r_en, wb_r.src1, wb_r.src1_used,
                             wb_r.src2, wb_r.src2_used};

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Scoreboard bench for forward_hazard_unit: every cycle the stimulus side
// predicts the outputs from an instruction-history model and queues them;
// a monitor on the falling edge pops and compares.
module tb_forward_hazard_unit;

  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          fwd_en;
  logic          hold;
  logic [3:0]    id_src1;
  logic          id_src1_used;
  logic [3:0]    id_src2;
  logic          id_src2_used;
  logic [3:0]    id_dest;
  logic          id_wb_en;
  logic          id_mem_r_en;
  logic          branch_taken;
  logic [1:0]    sel_src_1;
  logic [1:0]    sel_src_2;
  logic          hazard_stall;
  logic          flush;
  logic [CW-1:0] stall_count;

  always #5 clk = ~clk;

  forward_hazard_unit #(.CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .fwd_en       (fwd_en),
    .hold         (hold),
    .id_src1      (id_src1),
    .id_src1_used (id_src1_used),
    .id_src2      (id_src2),
    .id_src2_used (id_src2_used),
    .id_dest      (id_dest),
    .id_wb_en     (id_wb_en),
    .id_mem_r_en  (id_mem_r_en),
    .branch_taken (branch_taken),
    .sel_src_1    (sel_src_1),
    .sel_src_2    (sel_src_2),
    .hazard_stall (hazard_stall),
    .flush        (flush),
    .stall_count  (stall_count)
  );

  typedef struct packed {
    logic       v;
    logic       wb;
    logic       ld;
    logic [3:0] d;
    logic [3:0] s1;
    logic       u1;
    logic [3:0] s2;
    logic       u2;
  } ins_t;

  typedef struct packed {
    logic [1:0]    s1;
    logic [1:0]    s2;
    logic          st;
    logic          fl;
    logic [CW-1:0] cnt;
  } exp_t;

  // Instructions in flight, youngest first: [0]=EX, [1]=MEM, [2]=WB.
  ins_t          hist [3];
  logic [CW-1:0] m_cnt;
  exp_t          sbq [$];
  exp_t          cur_exp;
  ins_t          cur_id;
  logic          cur_fe, cur_h, cur_br, cur_rs;
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;

  localparam ins_t NOP = '0;

  function automatic ins_t mk(input logic wb, input logic ld, input int d,
                              input int s1, input logic u1, input int s2, input logic u2);
    ins_t r;
    r.v  = 1'b1;
    r.wb = wb;
    r.ld = ld;
    r.d  = 4'(d);
    r.s1 = 4'(s1);
    r.u1 = u1;
    r.s2 = 4'(s2);
    r.u2 = u2;
    return r;
  endfunction

  function automatic logic writes(input ins_t e, input logic [3:0] s, input logic u);
    return u && e.v && e.wb && (e.d == s);
  endfunction

  // Nearest older writer supplies the operand; a load still in MEM cannot.
  function automatic logic [1:0] model_sel(input logic [3:0] s, input logic u);
    if (!cur_fe) return 2'd0;
    if (writes(hist[1], s, u) && !hist[1].ld) return 2'd1;
    if (writes(hist[2], s, u)) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic model_stall(input ins_t id);
    logic r;
    r = 1'b0;
    if (cur_fe) begin
      r = hist[0].ld && (writes(hist[0], id.s1, id.u1) || writes(hist[0], id.s2, id.u2));
    end else begin
      for (int a = 0; a < 2; a++)
        r = r || writes(hist[a], id.s1, id.u1) || writes(hist[a], id.s2, id.u2);
    end
    return r && !cur_br;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  // Apply one cycle of inputs and queue the outputs the model predicts.
  task automatic drive(input ins_t id, input logic fe, input logic h,
                       input logic br, input logic rs);
    cur_id = id; cur_fe = fe; cur_h = h; cur_br = br; cur_rs = rs;
    rst = rs; fwd_en = fe; hold = h; branch_taken = br;
    id_src1 = id.s1; id_src1_used = id.u1;
    id_src2 = id.s2; id_src2_used = id.u2;
    id_dest = id.d;  id_wb_en = id.wb; id_mem_r_en = id.ld;
    cur_exp.s1  = model_sel(hist[0].s1, hist[0].u1);
    cur_exp.s2  = model_sel(hist[0].s2, hist[0].u2);
    cur_exp.st  = model_stall(id);
    cur_exp.fl  = br;
    cur_exp.cnt = m_cnt;
    sbq.push_back(cur_exp);
  endtask

  // Clock edge: move the instruction history the way the pipeline would.
  task automatic tick();
    @(posedge clk);
    cyc++;
    if (!cur_rs) begin
      for (int a = 0; a < 3; a++) hist[a] = NOP;
      m_cnt = '0;
    end else if (!cur_h) begin
      if (cur_exp.st && (m_cnt != {CW{1'b1}})) m_cnt = m_cnt + CW'(1);
      hist[2] = hist[1];
      hist[1] = hist[0];
      if (cur_exp.st || cur_br) begin
        hist[0] = NOP;
      end else begin
        hist[0]   = cur_id;
        hist[0].v = 1'b1;
      end
    end
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Monitor: outputs are presented every cycle; compare against the queue head.
  always @(negedge clk) begin
    exp_t e;
    exp_t g;
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      g = {sel_src_1, sel_src_2, hazard_stall, flush, stall_count};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL sb_cycle%0d: got sel1=%0d sel2=%0d stall=%0b flush=%0b cnt=%0d expected sel1=%0d sel2=%0d stall=%0b flush=%0b cnt=%0d",
                 cyc, g.s1, g.s2, g.st, g.fl, g.cnt, e.s1, e.s2, e.st, e.fl, e.cnt);
      end
    end
  end

  initial begin
    ins_t add_r1, ldr_r5, use_r5;
    logic fe;
    rst = 1'b0; fwd_en = 1'b1; hold = 1'b0; branch_taken = 1'b0;
    id_src1 = 4'h0; id_src1_used = 1'b0; id_src2 = 4'h0; id_src2_used = 1'b0;
    id_dest = 4'h0; id_wb_en = 1'b0; id_mem_r_en = 1'b0;
    for (int a = 0; a < 3; a++) hist[a] = NOP;
    m_cnt = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state.
    drive(NOP, 1'b1, 1'b0, 1'b0, 1'b1); settle();
    chk("rst_sel1", 32'(sel_src_1), 32'd0);
    chk("rst_sel2", 32'(sel_src_2), 32'd0);
    chk("rst_stall", 32'(hazard_stall), 32'd0);
    chk("rst_cnt", 32'(stall_count), 32'd0);
    tick();

    // ADD r1 ; SUB r2,r1,r3 -> MEM forward on operand 1.
    add_r1 = mk(1'b1, 1'b0, 1, 2, 1'b1, 3, 1'b1);
    drive(add_r1, 1'b1, 1'b0, 1'b0, 1'b1); tick();
    drive(mk(1'b1, 1'b0, 2, 1, 1'b1, 3, 1'b1), 1'b1, 1'b0, 1'b0, 1'b1); settle();
    chk("addsub_nostall", 32'(hazard_stall), 32'd0);
    tick();
    drive(NOP, 1'b1, 1'b0, 1'b0, 1'b1); settle();
    chk("addsub_sel1", 32'(sel_src_1), 32'd1);
    chk("addsub_sel2", 32'(sel_src_2), 32'd0);
    tick();

    // ADD r1 ; unrelated ; ORR r4,r0,r1 -> WB forward on operand 2.
    drive(add_r1, 1'b1, 1'b0, 1'b0, 1'b1); tick();
    drive(mk(1'b1, 1'b0, 7, 8, 1'b1, 9, 1'b1), 1'b1, 1'b0, 1'b0, 1'b1); tick();
    drive(mk(1'b1, 1'b0, 4, 0, 1'b1, 1, 1'b1), 1'b1, 1'b0, 1'b0, 1'b1); tick();
    drive(NOP, 1'b1, 1'b0, 1'b0, 1'b1); settle();
    chk("orr_sel2_wb", 32'(sel_src_2), 32'd2);
    tick();

    // r1 written in both MEM and WB -> MEM wins.
    drive(add_r1, 1'b1, 1'b0, 1'b0, 1'b1); tick();
    drive(mk(1'b1, 1'b0, 1, 5, 1'b1, 6, 1'b1), 1'b1, 1'b0, 1'b0, 1'b1); tick();
    drive(mk(1'b1, 1'b0, 2, 1, 1'b1, 3, 1'b1), 1'b1, 1'b0, 1'b0, 1'b1); tick();
    drive(NOP, 1'b1, 1'b0, 1'b0, 1'b1); settle();
    chk("mem_beats_wb", 32'(sel_src_1), 32'd1);
    tick();

    // LDR r5 ; ADD r6,r5,r5 -> one stall, bubble, then WB forward.
    ldr_r5 = mk(1'b1, 1'b1, 5, 0, 1'b1, 0, 1'b0);
    use_r5 = mk(1'b1, 1'b0, 6, 5, 1'b1, 5, 1'b1);
    drive(ldr_r5, 1'b1, 1'b0, 1'b0, 1'b1); tick();
    drive(use_r5, 1'b1, 1'b0, 1'b0, 1'b1); settle();
    chk("ldu_stall1", 32'(hazard_stall), 32'd1);
    tick();
    drive(use_r5, 1'b1, 1'b0, 1'b0, 1'b1); settle();
    chk("ldu_stall2", 32'(hazard_stall), 32'd0);
    tick();
    drive(NOP, 1'b1, 1'b0, 1'b0, 1'b1); settle();
    chk("ldu_sel1", 32'(sel_src_1), 32'd2);
    chk("ldu_sel2", 32'(sel_src_2), 32'd2);
    chk("ldu_cnt", 32'(stall_count), 32'd1);
    tick();

    // fwd_en=0: MOV r2 ; ADD r3,r2,r2 -> two stalls, selects 00.
    drive(mk(1'b1, 1'b0, 2, 0, 1'b0, 0, 1'b0), 1'b0, 1'b0, 1'b0, 1'b1); tick();
    for (int i = 0; i < 3; i++) begin
      drive(mk(1'b1, 1'b0, 3, 2, 1'b1, 2, 1'b1), 1'b0, 1'b0, 1'b0, 1'b1); settle();
      chk($sformatf("nofwd_stall%0d", i), 32'(hazard_stall), (i < 2) ? 32'd1 : 32'd0);
      tick();
    end
    drive(NOP, 1'b0, 1'b0, 1'b0, 1'b1); settle();
    chk("nofwd_sel1", 32'(sel_src_1), 32'd0);
    chk("nofwd_cnt", 32'(stall_count), 32'd3);
    tick();

    // Load-use coinciding with a taken branch.
    drive(ldr_r5, 1'b1, 1'b0, 1'b0, 1'b1); tick();
    drive(use_r5, 1'b1, 1'b0, 1'b1, 1'b1); settle();
    chk("br_flush", 32'(flush), 32'd1);
    chk("br_nostall", 32'(hazard_stall), 32'd0);
    tick();
    drive(mk(1'b0, 1'b0, 0, 6, 1'b1, 0, 1'b0), 1'b0, 1'b0, 1'b0, 1'b1); settle();
    chk("br_ex_bubble", 32'(hazard_stall), 32'd0);
    chk("br_cnt", 32'(stall_count), 32'd3);
    tick();

    // Load-use stall held for three cycles.
    drive(ldr_r5, 1'b1, 1'b0, 1'b0, 1'b1); tick();
    for (int i = 0; i < 3; i++) begin
      drive(use_r5, 1'b1, 1'b1, 1'b0, 1'b1); tick();
    end
    drive(use_r5, 1'b1, 1'b0, 1'b0, 1'b1); settle();
    chk("hold_stall", 32'(hazard_stall), 32'd1);
    chk("hold_cnt", 32'(stall_count), 32'd3);
    tick();
    drive(use_r5, 1'b1, 1'b0, 1'b0, 1'b1); settle();
    chk("hold_cnt_after", 32'(stall_count), 32'd4);
    tick();

    // Drive the counter into saturation.
    for (int i = 0; i < 120; i++) begin
      drive(mk(1'b1, 1'b0, 1, 1, 1'b1, 0, 1'b0), 1'b0, 1'b0, 1'b0, 1'b1); tick();
    end
    drive(NOP, 1'b0, 1'b0, 1'b0, 1'b1); settle();
    chk("sat_cnt", 32'(stall_count), 32'(2 ** CW - 1));
    tick();

    // Reset pulled mid-stall.
    drive(mk(1'b1, 1'b0, 1, 0, 1'b0, 0, 1'b0), 1'b0, 1'b0, 1'b0, 1'b1); tick();
    drive(mk(1'b0, 1'b0, 0, 1, 1'b1, 0, 1'b0), 1'b0, 1'b0, 1'b0, 1'b0); settle();
    chk("rstmid_stall_before", 32'(hazard_stall), 32'd1);
    tick();
    drive(mk(1'b0, 1'b0, 0, 1, 1'b1, 0, 1'b0), 1'b0, 1'b0, 1'b1, 1'b0); settle();
    chk("rstmid_stall", 32'(hazard_stall), 32'd0);
    chk("rstmid_flush", 32'(flush), 32'd1);
    chk("rstmid_cnt", 32'(stall_count), 32'd0);
    tick();

    // Randomised traffic over a small register set to provoke collisions.
    fe = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      ins_t r;
      if ($urandom_range(0, 15) == 0) fe = ~fe;
      r = mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      drive(r, fe, 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 99) != 0));
      tick();
    end

    @(negedge clk);
    #1;
    chk("sb_drain", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
